// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared constants and types for the RAS front-end controller
//
// Purpose: opcode and link-register constants, controller state encoding and the
//          RAS command bundle shared by ras_call_decode and ras_ctrl.
// Ports:   none (package).
// Config:  RAS_CTRL_RVC_EN adds the compressed-instruction field constants.
package ras_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

`ifdef RAS_CTRL_RVC_EN
  localparam logic [1:0] RVC_Q1     = 2'b01;
  localparam logic [1:0] RVC_Q2     = 2'b10;
  localparam logic [2:0] C1_JAL     = 3'b001;
  localparam logic [2:0] C1_BEQZ    = 3'b110;
  localparam logic [2:0] C1_BNEZ    = 3'b111;
  localparam logic [2:0] C2_JR_JALR = 3'b100;
`endif

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PRED_WAIT = 2'd1,
    RECOVER   = 2'd2
  } ras_ctrl_state_t;

  typedef struct packed {
    logic push;
    logic pop;
    logic branch;
  } ras_cmd_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_call_decode.sv
// rtl/ras_call_decode.sv - combinational call/return/branch decoder for the RAS
//
// Purpose: classify a fetched instruction into RAS push/pop/branch hints.
// Ports:
//   instr          in   32  fetched instruction word
//   cmd            out  3   {push, pop, branch} hint (not yet qualified by handshake)
//   is_compressed  out  1   instruction is a 16-bit form (return address is pc+2)
// Config: RAS_CTRL_RVC_EN enables 16-bit decode; otherwise non-32-bit encodings
//         decode to no RAS activity.
module ras_call_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr,
  output ras_cmd_t    cmd,
  output logic        is_compressed
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_bits;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // Immediate and funct fields never influence the RAS decision.
  assign unused_bits = ^{instr[31:20], instr[14:12]};

  always_comb begin
    cmd           = '0;
    is_compressed = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_JAL: cmd.push = rd_link;
        OPC_JALR: begin
          // Writing a link register is a call; reading one is a return.
          // Same link register on both sides is a plain call (coroutine
          // swap only applies when the registers differ).
          cmd.push = rd_link;
          cmd.pop  = rs1_link && !(rd_link && (rd == rs1));
        end
        OPC_BRANCH: cmd.branch = 1'b1;
        default: ;
      endcase
    end
`ifdef RAS_CTRL_RVC_EN
    else begin
      is_compressed = 1'b1;
      if (instr[1:0] == RVC_Q1) begin
        // c.jal always links through x1.
        if (instr[15:13] == C1_JAL) cmd.push = 1'b1;
        if ((instr[15:13] == C1_BEQZ) || (instr[15:13] == C1_BNEZ)) cmd.branch = 1'b1;
      end else if ((instr[1:0] == RVC_Q2) && (instr[15:13] == C2_JR_JALR) &&
                   (instr[6:2] == 5'd0) && (rd != 5'd0)) begin
        if (instr[12]) begin
          // c.jalr writes x1; a return through x5 is a coroutine swap.
          cmd.push = 1'b1;
          cmd.pop  = (rd == LINK_X5);
        end else begin
          cmd.pop = rd_link;
        end
      end
    end
`endif
  end

endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return address stack front-end controller
//
// Purpose: turns accepted fetches into RAS push/pop/branch commands, returns the
//          predicted return target one cycle after a pop, limits speculation
//          depth and converts branch resolution into checkpoint close commands.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   fetch_valid/fetch_ready           instruction handshake (transfer = valid && ready)
//   fetch_pc, fetch_instr             presented instruction
//   pred_valid, pred_target           return prediction (one bubble after a pop)
//   resolve_valid, resolve_mispred    oldest outstanding branch resolved / mispredicted
//   ras_push, ras_pop, ras_branch     RAS commands
//   ras_close_valid, ras_close_invalid RAS checkpoint close commands
//   ras_din                           return address pushed
//   ras_dout, ras_empty               RAS top-of-stack data and empty flag
// Config: RAS_CTRL_RVC_EN enables compressed-instruction decode.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MAX_BRANCHES  = 16,
  parameter int ADDR_BRANCHES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic [31:0]      fetch_instr,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_target,
  input  logic             resolve_valid,
  input  logic             resolve_mispred,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty
);

  localparam logic [ADDR_BRANCHES:0] MAX_CNT = (ADDR_BRANCHES+1)'(MAX_BRANCHES);
  localparam logic [ADDR_BRANCHES:0] CNT_ONE = (ADDR_BRANCHES+1)'(1);
  localparam logic [WIDTH-1:0]       STEP_32 = WIDTH'(4);
  localparam logic [WIDTH-1:0]       STEP_16 = WIDTH'(2);

  ras_ctrl_state_t        state_q, state_d;
  logic [ADDR_BRANCHES:0] outstanding_q, outstanding_d;
  logic                   boot_q;

  ras_cmd_t cmd;
  logic     is_compressed;
  logic     have_outstanding;
  logic     resolve_ok;
  logic     mispredict;
  logic     accept;

  ras_call_decode u_decode (
    .instr         (fetch_instr),
    .cmd           (cmd),
    .is_compressed (is_compressed)
  );

  // boot_q holds fetch off for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      boot_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      boot_q        <= 1'b1;
    end
  end

  always_comb begin
    state_d           = state_q;
    outstanding_d     = outstanding_q;
    fetch_ready       = 1'b0;
    accept            = 1'b0;
    ras_push          = 1'b0;
    ras_pop           = 1'b0;
    ras_branch        = 1'b0;
    ras_din           = '0;
    pred_valid        = 1'b0;
    pred_target       = '0;
    ras_close_valid   = 1'b0;
    ras_close_invalid = 1'b0;

    // A resolution with nothing outstanding is stale and is dropped.
    have_outstanding = (outstanding_q != '0);
    resolve_ok       = resolve_valid && have_outstanding;
    mispredict       = resolve_ok && resolve_mispred;

    // Mispredict wins over a same-cycle fetch; only branches are throttled
    // when every checkpoint slot is in use.
    fetch_ready = boot_q && (state_q == RUN) && !mispredict &&
                  !(cmd.branch && (outstanding_q == MAX_CNT));
    accept      = fetch_valid && fetch_ready;

    ras_push   = accept && cmd.push;
    ras_pop    = accept && cmd.pop && !ras_empty;
    ras_branch = accept && cmd.branch;
    if (ras_push) ras_din = fetch_pc + (is_compressed ? STEP_16 : STEP_32);

    pred_valid  = (state_q == PRED_WAIT) && !mispredict;
    pred_target = pred_valid ? ras_dout : '0;

    ras_close_valid   = resolve_ok && !resolve_mispred;
    ras_close_invalid = mispredict;

    case (state_q)
      RUN:       if (ras_pop) state_d = PRED_WAIT;
      PRED_WAIT: state_d = RUN;
      RECOVER:   state_d = RUN;
      default:   state_d = RUN;
    endcase

    case ({ras_branch, resolve_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    // Recovery flushes all speculation, including a pending prediction.
    if (mispredict) begin
      state_d       = RECOVER;
      outstanding_d = '0;
    end
  end

  // The branch unit must never resolve more branches than were issued.
  assert property (@(posedge clk) disable iff (!reset_n) resolve_valid |-> have_outstanding);

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - self-checking bench for ras_ctrl
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic        resolve_mispred;
  logic        ras_push, ras_pop, ras_branch;
  logic        ras_close_valid, ras_close_invalid;
  logic [31:0] ras_din;
  logic [31:0] ras_dout;
  logic        ras_empty;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] CJAL = 32'h0000_2001;

  always #5 clk = ~clk;

  ras_ctrl #(.WIDTH(32), .MAX_BRANCHES(16), .ADDR_BRANCHES(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_pc          (fetch_pc),
    .fetch_instr       (fetch_instr),
    .pred_valid        (pred_valid),
    .pred_target       (pred_target),
    .resolve_valid     (resolve_valid),
    .resolve_mispred   (resolve_mispred),
    .ras_push          (ras_push),
    .ras_pop           (ras_pop),
    .ras_branch        (ras_branch),
    .ras_close_valid   (ras_close_valid),
    .ras_close_invalid (ras_close_invalid),
    .ras_din           (ras_din),
    .ras_dout          (ras_dout),
    .ras_empty         (ras_empty)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_n, act, exp);
  endtask

  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h0, rd, 7'h6F};
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'h67};
  endfunction

  // Reference classification straight from the calling-convention rules.
  function automatic void model_decode(input logic [31:0] ins, output bit psh, output bit pp,
                                       output bit br, output bit cmp);
    bit rd_l, rs_l;
    psh = 0; pp = 0; br = 0; cmp = 0;
    rd_l = (ins[11:7] == 5'd1) || (ins[11:7] == 5'd5);
    rs_l = (ins[19:15] == 5'd1) || (ins[19:15] == 5'd5);
    if (ins[1:0] == 2'b11) begin
      if (ins[6:0] == 7'h6F) psh = rd_l;
      else if (ins[6:0] == 7'h63) br = 1;
      else if (ins[6:0] == 7'h67) begin
        case ({rd_l, rs_l})
          2'b10: psh = 1;
          2'b01: pp = 1;
          2'b11: begin psh = 1; pp = (ins[11:7] != ins[19:15]); end
          default: ;
        endcase
      end
    end
`ifdef RAS_CTRL_RVC_EN
    else begin
      cmp = 1;
      if (ins[1:0] == 2'b01 && ins[15:13] == 3'b001) psh = 1;
      if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) br = 1;
      if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && ins[6:2] == 0 && ins[11:7] != 0) begin
        if (ins[12]) begin psh = 1; pp = (ins[11:7] == 5'd5); end
        else pp = rd_l;
      end
    end
`endif
  endfunction

  // Model state: branches in flight, prediction bubble pending, recovery bubble, boot bubble.
  int m_out;
  bit m_pend, m_rec, m_boot;

  initial begin
    int          nx_out;
    bit          nx_pend, nx_rec;
    bit          d_push, d_pop, d_br, d_c, res_ok, mis, rdy, acc;
    bit          e_push, e_pop, e_br, e_pv, e_cv, e_ci;
    logic [31:0] e_din, e_pt;
    m_out = 0; m_pend = 0; m_rec = 0; m_boot = 0;
    nx_out = 0; nx_pend = 0; nx_rec = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_out = 0; m_pend = 0; m_rec = 0; m_boot = 0;
        rdy = 0; e_push = 0; e_pop = 0; e_br = 0; e_pv = 0; e_cv = 0; e_ci = 0;
        e_din = 0; e_pt = 0;
      end else begin
        model_decode(fetch_instr, d_push, d_pop, d_br, d_c);
        res_ok = resolve_valid && (m_out > 0);
        mis    = res_ok && resolve_mispred;
        rdy    = m_boot && !m_pend && !m_rec && !mis && !(d_br && m_out >= 16);
        acc    = fetch_valid && rdy;
        e_push = acc && d_push;
        e_pop  = acc && d_pop && !ras_empty;
        e_br   = acc && d_br;
        e_din  = e_push ? fetch_pc + (d_c ? 32'd2 : 32'd4) : 32'd0;
        e_pv   = m_pend && !mis;
        e_pt   = e_pv ? ras_dout : 32'd0;
        e_cv   = res_ok && !resolve_mispred;
        e_ci   = mis;
        if (mis) begin
          nx_out = 0; nx_pend = 0; nx_rec = 1;
        end else begin
          nx_out  = m_out + (e_br ? 1 : 0) - (res_ok ? 1 : 0);
          nx_pend = e_pop;
          nx_rec  = 0;
        end
      end
      check("cmp_fetch_ready", 32'(fetch_ready), 32'(rdy));
      check("cmp_ras_push", 32'(ras_push), 32'(e_push));
      check("cmp_ras_pop", 32'(ras_pop), 32'(e_pop));
      check("cmp_ras_branch", 32'(ras_branch), 32'(e_br));
      check("cmp_ras_din", ras_din, e_din);
      check("cmp_pred_valid", 32'(pred_valid), 32'(e_pv));
      check("cmp_pred_target", pred_target, e_pt);
      check("cmp_close_valid", 32'(ras_close_valid), 32'(e_cv));
      check("cmp_close_invalid", 32'(ras_close_invalid), 32'(e_ci));
      @(posedge clk);
      if (!reset_n) begin
        m_out = 0; m_pend = 0; m_rec = 0; m_boot = 0;
      end else begin
        m_out = nx_out; m_pend = nx_pend; m_rec = nx_rec; m_boot = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = ins;
  endtask

  logic [31:0] sweep [8];

  initial begin
    reset_n = 0; fetch_valid = 0; fetch_pc = 0; fetch_instr = NOP;
    resolve_valid = 0; resolve_mispred = 0; ras_dout = 0; ras_empty = 0;
    sweep[0] = jalr(5'd1, 5'd1); sweep[1] = jalr(5'd1, 5'd5); sweep[2] = jalr(5'd5, 5'd5);
    sweep[3] = jal(5'd0);        sweep[4] = jal(5'd5);        sweep[5] = jalr(5'd0, 5'd5);
    sweep[6] = jalr(5'd2, 5'd3); sweep[7] = NOP;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(fetch_ready), 32'd0);
    check("reset_push", 32'(ras_push), 32'd0);
    cyc(); reset_n = 1;
    @(negedge clk); check("boot_ready", 32'(fetch_ready), 32'd0);
    cyc();
    @(negedge clk); check("ready_after_boot", 32'(fetch_ready), 32'd1);

    // Call then return
    cyc(); fetch(1, 32'h100, jal(5'd1));
    @(negedge clk);
    check("jal_push", 32'(ras_push), 32'd1);
    check("jal_din", ras_din, 32'h104);
    cyc(); fetch(1, 32'h104, jalr(5'd0, 5'd1)); ras_dout = 32'h104;
    @(negedge clk); check("ret_pop", 32'(ras_pop), 32'd1);
    cyc(); fetch(0, 32'h0, NOP);
    @(negedge clk);
    check("ret_pred_valid", 32'(pred_valid), 32'd1);
    check("ret_pred_target", pred_target, 32'h104);
    check("ret_bubble", 32'(fetch_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("ret_pred_drop", 32'(pred_valid), 32'd0);
    check("ret_ready_back", 32'(fetch_ready), 32'd1);

    // Coroutine swap
    cyc(); fetch(1, 32'h200, jalr(5'd5, 5'd1)); ras_dout = 32'h204;
    @(negedge clk);
    check("swap_pop", 32'(ras_pop), 32'd1);
    check("swap_push", 32'(ras_push), 32'd1);
    check("swap_din", ras_din, 32'h204);
    cyc(); fetch(0, 32'h0, NOP);

    // Remaining link-register combinations, each followed by an idle cycle
    for (int i = 0; i < 8; i++) begin
      cyc(); fetch(1, 32'h210 + 32'(i * 4), sweep[i]);
      cyc(); fetch(0, 32'h0, NOP);
    end

    // Return with empty stack
    cyc(); ras_empty = 1; fetch(1, 32'h240, jalr(5'd0, 5'd1));
    @(negedge clk); check("empty_no_pop", 32'(ras_pop), 32'd0);
    cyc(); fetch(1, 32'h244, NOP);
    @(negedge clk);
    check("empty_no_pred", 32'(pred_valid), 32'd0);
    check("empty_ready", 32'(fetch_ready), 32'd1);
    cyc(); ras_empty = 0; fetch(0, 32'h0, NOP);

    // Fill all 16 checkpoint slots
    for (int i = 0; i < 16; i++) begin
      cyc(); fetch(1, 32'h400 + 32'(i * 4), BEQ);
    end
    cyc(); fetch(1, 32'h440, NOP);
    @(negedge clk); check("nop_at_full", 32'(fetch_ready), 32'd1);
    cyc(); fetch(1, 32'h444, BEQ);
    @(negedge clk); check("branch_at_full", 32'(fetch_ready), 32'd0);
    cyc(); resolve_valid = 1;
    @(negedge clk);
    check("full_resolve_ready", 32'(fetch_ready), 32'd0);
    check("full_close_valid", 32'(ras_close_valid), 32'd1);
    cyc(); resolve_valid = 0;
    @(negedge clk); check("after_resolve_branch", 32'(ras_branch), 32'd1);
    cyc(); fetch(1, 32'h448, BEQ);
    @(negedge clk); check("full_again_16", 32'(fetch_ready), 32'd0);

    // Mispredict at full depth
    cyc(); resolve_valid = 1; resolve_mispred = 1;
    @(negedge clk);
    check("mis_close_invalid", 32'(ras_close_invalid), 32'd1);
    check("mis_ready", 32'(fetch_ready), 32'd0);
    cyc(); resolve_valid = 0; resolve_mispred = 0;
    @(negedge clk); check("recover_ready", 32'(fetch_ready), 32'd0);
    cyc();
    @(negedge clk); check("post_recover_branch", 32'(ras_branch), 32'd1);

    // Three outstanding, mispredict against a same-cycle call
    cyc(); fetch(1, 32'h44C, BEQ);
    cyc(); fetch(1, 32'h450, BEQ);
    cyc(); fetch(1, 32'h500, jal(5'd1)); resolve_valid = 1; resolve_mispred = 1;
    @(negedge clk);
    check("mis3_close_invalid", 32'(ras_close_invalid), 32'd1);
    check("mis3_no_push", 32'(ras_push), 32'd0);
    cyc(); resolve_valid = 0; resolve_mispred = 0;
    @(negedge clk); check("mis3_recover", 32'(fetch_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("mis3_push", 32'(ras_push), 32'd1);
    check("mis3_din", ras_din, 32'h504);

    // Mispredict while a return prediction is pending
    cyc(); fetch(1, 32'h600, BEQ);
    cyc(); fetch(1, 32'h604, jalr(5'd0, 5'd1)); ras_dout = 32'h504;
    cyc(); fetch(0, 32'h0, NOP); resolve_valid = 1; resolve_mispred = 1;
    @(negedge clk); check("mis_pred_drop", 32'(pred_valid), 32'd0);
    cyc(); resolve_valid = 0; resolve_mispred = 0;
    cyc();

    // Branch and resolve together leave the count unchanged
    cyc(); fetch(1, 32'h700, BEQ);
    cyc(); fetch(1, 32'h704, BEQ); resolve_valid = 1;
    cyc(); fetch(0, 32'h0, NOP);
    cyc(); resolve_valid = 0;

    // Count is back to zero: exactly 16 branches fit again
    for (int i = 0; i < 16; i++) begin
      cyc(); fetch(1, 32'h800 + 32'(i * 4), BEQ);
    end
    cyc(); fetch(1, 32'h840, BEQ);
    @(negedge clk); check("refill_stall", 32'(fetch_ready), 32'd0);
    cyc(); resolve_valid = 1; resolve_mispred = 1;
    cyc(); resolve_valid = 0; resolve_mispred = 0; fetch(0, 32'h0, NOP);
    cyc();

    // Compressed call
    cyc(); fetch(1, 32'h300, CJAL);
    @(negedge clk);
`ifdef RAS_CTRL_RVC_EN
    check("cjal_push", 32'(ras_push), 32'd1);
    check("cjal_din", ras_din, 32'h302);
`else
    check("cjal_no_push", 32'(ras_push), 32'd0);
    check("cjal_no_pop", 32'(ras_pop), 32'd0);
`endif
    cyc(); fetch(0, 32'h0, NOP);

    // Reset during a pending prediction
    cyc(); fetch(1, 32'h900, jalr(5'd0, 5'd1)); ras_dout = 32'h904;
    cyc(); fetch(0, 32'h0, NOP); reset_n = 0;
    @(negedge clk);
    check("rst_pred_dropped", 32'(pred_valid), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd0);
    cyc(); reset_n = 1;
    @(negedge clk); check("rst_boot_ready", 32'(fetch_ready), 32'd0);
    cyc();
    @(negedge clk); check("rst_ready_back", 32'(fetch_ready), 32'd1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
